// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache fetches and dcache reads/writes share one
// main-memory port. Each port has a single pending slot. Ties are broken
// toward the port that was not served last. A sticky flag reports memory
// waits that reach TIMEOUT cycles; the stalled transaction keeps waiting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction in flight, pick a pending slot to serve
// BUSY_I | m_req driven from the icache slot, waiting for m_ready
// BUSY_D | m_req driven from the dcache slot, waiting for m_ready
// RESP_I | one-cycle i_ready pulse, icache slot released
// RESP_D | one-cycle d_ready pulse, dcache slot released
module mem_arbiter #(
  parameter int PHY_LEN = 20,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [PHY_LEN-1:0] i_addr,
  output logic               i_ready,
  output logic [LINE_W-1:0]  i_data,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [PHY_LEN-1:0] d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic               d_ready,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               m_req,
  output logic               m_we,
  output logic [PHY_LEN-1:0] m_addr,
  output logic [LINE_W-1:0]  m_wdata,
  input  logic               m_ready,
  input  logic [LINE_W-1:0]  m_rdata,
  output logic               err_overrun,
  output logic               err_timeout
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  // Wide enough to hold TIMEOUT itself; the counter loads it and counts down.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);

  state_t             state;
  logic               last_d;
  logic [CNT_W-1:0]   wait_cnt;

  logic               i_pend;
  logic [PHY_LEN-1:0] i_addr_q;
  logic               d_pend;
  logic               d_we_q;
  logic [PHY_LEN-1:0] d_addr_q;
  logic [LINE_W-1:0]  d_wdata_q;

  logic               i_done;
  logic               d_done;

  // A slot is freed during its response cycle, so a strobe then refills it.
  assign i_done = (state == RESP_I);
  assign d_done = (state == RESP_D);

  // Pending slots: accept a strobe into a free or completing slot, flag the rest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_pend      <= 1'b0;
      i_addr_q    <= '0;
      d_pend      <= 1'b0;
      d_we_q      <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (i_req && (!i_pend || i_done)) begin
        i_pend   <= 1'b1;
        i_addr_q <= i_addr;
      end else if (i_done) begin
        i_pend <= 1'b0;
      end

      if (d_req && (!d_pend || d_done)) begin
        d_pend    <= 1'b1;
        d_we_q    <= d_we;
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
      end else if (d_done) begin
        d_pend <= 1'b0;
      end

      if ((i_req && i_pend && !i_done) || (d_req && d_pend && !d_done))
        err_overrun <= 1'b1;
    end
  end

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      wait_cnt    <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_ready     <= 1'b0;
      i_data      <= '0;
      d_ready     <= 1'b0;
      d_rdata     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pend && (!d_pend || last_d)) begin
            state    <= BUSY_I;
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_addr   <= i_addr_q;
            m_wdata  <= '0;
            wait_cnt <= WAIT_LOAD;
          end else if (d_pend) begin
            state    <= BUSY_D;
            m_req    <= 1'b1;
            m_we     <= d_we_q;
            m_addr   <= d_addr_q;
            m_wdata  <= d_wdata_q;
            wait_cnt <= WAIT_LOAD;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ready) begin
            m_req <= 1'b0;
            if (state == BUSY_I) begin
              i_data  <= m_rdata;
              i_ready <= 1'b1;
              state   <= RESP_I;
            end else begin
              d_rdata <= m_rdata;
              d_ready <= 1'b1;
              state   <= RESP_D;
            end
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_ONE;
            if (wait_cnt == WAIT_ONE)
              err_timeout <= 1'b1;
          end
        end
        RESP_I: begin
          i_ready <= 1'b0;
          last_d  <= 1'b0;
          state   <= IDLE;
        end
        RESP_D: begin
          d_ready <= 1'b0;
          last_d  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter PHY_LEN, default 20, meaning physical address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning cache-line data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning memory wait limit in cycles before a timeout is flagged.
REQ-004 The block SHALL have port clk  in  1  core clock, all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 The block SHALL have ports i_req in 1 (icache miss strobe); i_addr in PHY_LEN; i_ready out 1; i_data out LINE_W.
REQ-007 The block SHALL have ports d_req in 1 (dcache strobe); d_we in 1; d_addr in PHY_LEN; d_wdata in LINE_W; d_ready out 1; d_rdata out LINE_W.
REQ-008 The block SHALL have ports m_req out 1; m_we out 1; m_addr out PHY_LEN; m_wdata out LINE_W; m_ready in 1; m_rdata in LINE_W (main-memory side).
REQ-009 The block SHALL have ports err_overrun out 1 and err_timeout out 1, both sticky error flags.

Function
REQ-010 x_req SHALL be a one-cycle strobe; on the edge it is high and port x has no pending request, the block SHALL latch addr (and we/wdata for d) into pending slot x.
REQ-011 A strobe while slot x is pending and not completing SHALL be ignored (latched fields unchanged) and SHALL set err_overrun.
REQ-012 A strobe in the same cycle that x_ready is high SHALL be accepted as a new pending request.
REQ-013 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-014 IDLE: only I pending -> BUSY_I; only D pending -> BUSY_D; both -> the port not granted last; none -> stay.
REQ-015 The last-grant register SHALL reset to I, so the first tie after reset grants D.
REQ-016 On entering BUSY_x, m_req SHALL be 1 with m_addr/m_we/m_wdata from slot x (m_we = 0 for I), all registered and stable until m_ready.
REQ-017 In BUSY_x with m_ready = 1, the block SHALL capture m_rdata into x_data/x_rdata, drop m_req, and enter RESP_x.
REQ-018 RESP_x SHALL assert x_ready for exactly one cycle, clear slot x, update last-grant to x, and return to IDLE.
REQ-019 For a write, d_rdata SHALL still load m_rdata (don't-care content); d_ready SHALL pulse identically.
REQ-020 Latency SHALL be: strobe at cycle 0 into IDLE with no other pending -> m_req high at cycle 2; m_ready at cycle 2+k (k >= 0) -> x_ready at cycle 3+k.
REQ-021 i_data and d_rdata SHALL hold their last value until the next response for that port.
REQ-022 A wait counter SHALL count BUSY cycles with m_ready low; on reaching TIMEOUT it SHALL set err_timeout and saturate; the transaction SHALL NOT be aborted.
REQ-023 The counter SHALL clear on every entry to BUSY_x.
REQ-024 Error flags SHALL clear only on reset.
REQ-025 m_ready outside BUSY states SHALL be ignored.

Reset
REQ-026 While rst = 0, immediately and regardless of clk: state = IDLE, pending slots empty, last-grant = I, counter = 0, all outputs = 0.
REQ-027 Reset mid-transaction SHALL drop the transaction with no ready pulse; normal operation SHALL resume on the first edge after rst = 1.

Verification
REQ-028 Single fetch: i_req with i_addr = 0x40010 at cycle 0, m_ready at cycle 4 with m_rdata = A -> m_req 2..4, m_addr = 0x40010, m_we = 0, i_ready only at cycle 5, i_data = A.
REQ-029 Tie after reset: i_req and d_req in the same cycle -> D served first, then I; two m_req phases, order D,I.
REQ-030 Fairness: both ports re-strobe on every ready for 8 transactions -> grants strictly alternate D,I,D,I...
REQ-031 Write: d_we = 1, d_addr = 0x00100, d_wdata = B, m_ready delayed 5 cycles -> m_we = 1, m_wdata = B stable throughout, single d_ready pulse.
REQ-032 Overrun: second i_req (addr 0x00200) while first (0x40010) pending -> err_overrun = 1, memory sees only 0x40010.
REQ-033 Timeout/reset: m_ready withheld -> err_timeout = 1 after exactly 64 waiting cycles; then rst = 0 -> all outputs 0 asynchronously, no i_ready.
